lcd_nibble_driver: RTL and testbench

- Responder side of the LCD command handshake. Accepts level requests (reset/clear/home/addr/data) from the display sequencer.
- Executes each request as HD44780 4-bit write cycles with all required delays, then returns a per-request acknowledge.
- Drives the character LCD pins rslcd/rwlcd/elcd/lcdd directly. Write-only; busy flag never read.

---
 rtl/lcd_nibble_driver_pkg.sv | 54 +++++
 rtl/lcd_nibble_driver_if.sv | 25 ++
 rtl/lcd_nibble_driver_xfer.sv | 59 +++++
 rtl/lcd_nibble_driver.sv | 204 ++++++++++++++++++++
 tb/tb_lcd_nibble_driver.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_nibble_driver_pkg.sv
// rtl/lcd_nibble_driver_pkg.sv - op codes, states, LCD command bytes and helpers
package lcd_nibble_driver_pkg;

  typedef enum logic [2:0] {
    OP_RESET = 3'd0,
    OP_CLEAR = 3'd1,
    OP_HOME  = 3'd2,
    OP_ADDR  = 3'd3,
    OP_DATA  = 3'd4
  } op_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PWR,
    ST_INIT_STEP,
    ST_NIB_HI,
    ST_GAP,
    ST_NIB_LO,
    ST_POST,
    ST_DONE
  } state_t;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_DISPLAY = 8'h0C;
  localparam logic [7:0] CMD_FUNC    = 8'h28;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  // Down-counter reload: a wait of t cycles counts t-1..0, and 0 still costs one cycle.
  function automatic logic [19:0] wait_load(input int unsigned t);
    if (t == 0) return 20'd0;
    return 20'(t - 1);
  endfunction

  function automatic logic [3:0] init_nibble(input logic [3:0] step);
    return (step == 4'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [7:0] init_byte(input logic [3:0] step);
    case (step)
      4'd4:    return CMD_FUNC;
      4'd5:    return CMD_ENTRY;
      4'd6:    return CMD_DISPLAY;
      default: return CMD_CLEAR;
    endcase
  endfunction

  function automatic logic [4:0] ack_for(input op_t op);
    return 5'd1 << op;
  endfunction

endpackage

// File: rtl/lcd_nibble_driver_if.sv
// rtl/lcd_nibble_driver_if.sv - sequencer request/acknowledge handshake
interface lcd_nibble_driver_if;
  logic       resetlcd;
  logic       clearlcd;
  logic       homelcd;
  logic       addrlcd;
  logic       datalcd;
  logic [7:0] lcddatin;
  logic       initlcd;
  logic       lcdreset;
  logic       lcdclear;
  logic       lcdhome;
  logic       lcdaddr;
  logic       lcddata;

  modport master (
    output resetlcd, clearlcd, homelcd, addrlcd, datalcd, lcddatin, initlcd,
    input  lcdreset, lcdclear, lcdhome, lcdaddr, lcddata
  );

  modport slave (
    input  resetlcd, clearlcd, homelcd, addrlcd, datalcd, lcddatin, initlcd,
    output lcdreset, lcdclear, lcdhome, lcdaddr, lcddata
  );
endinterface

// File: rtl/lcd_nibble_driver_xfer.sv
// rtl/lcd_nibble_driver_xfer.sv - one 4-bit LCD write strobe with setup, enable and hold timing
module lcd_nibble_xfer #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_E     = 12,
  parameter int unsigned T_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic [3:0] lcdd,
  output logic       rslcd,
  output logic       elcd,
  output logic       xfer_done
);
  localparam int unsigned E_END = T_SETUP + T_E;
  localparam int unsigned TOTAL = E_END + T_HOLD;

  logic [15:0] cyc;
  logic        busy;
  logic [31:0] nxt;

  assign nxt = 32'(cyc) + 32'd1;

  function automatic logic e_window(input logic [31:0] c);
    return (c >= T_SETUP) && (c < E_END);
  endfunction

  // cyc is the index of the cycle currently on the pins; elcd is registered one ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcdd      <= 4'h0;
      rslcd     <= 1'b0;
      elcd      <= 1'b0;
      xfer_done <= 1'b0;
      cyc       <= 16'd0;
      busy      <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      if (start) begin
        lcdd  <= nibble;
        rslcd <= rs;
        cyc   <= 16'd0;
        busy  <= 1'b1;
        elcd  <= e_window(32'd0);
      end else if (busy) begin
        if (nxt >= TOTAL) begin
          busy      <= 1'b0;
          xfer_done <= 1'b1;
          elcd      <= 1'b0;
        end else begin
          cyc  <= cyc + 16'd1;
          elcd <= e_window(nxt);
        end
      end
    end
  end
endmodule

// File: rtl/lcd_nibble_driver.sv
// rtl/lcd_nibble_driver.sv - executes sequencer requests as HD44780 4-bit write cycles
module lcd_nibble_driver
  import lcd_nibble_driver_pkg::*;
#(
  parameter int unsigned T_PWRUP  = 750000,
  parameter int unsigned T_4100US = 205000,
  parameter int unsigned T_100US  = 5000,
  parameter int unsigned T_40US   = 2000,
  parameter int unsigned T_LONG   = 100000,
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_E      = 12,
  parameter int unsigned T_HOLD   = 2,
  parameter int unsigned T_NIB    = 50
) (
  input  logic                CCLK,
  input  logic                reset,
  lcd_nibble_driver_if.slave  bus,
  output logic                rslcd,
  output logic                rwlcd,
  output logic                elcd,
  output logic [3:0]          lcdd
);
  localparam logic [19:0] W_PWRUP = wait_load(T_PWRUP);
  localparam logic [19:0] W_4100  = wait_load(T_4100US);
  localparam logic [19:0] W_100   = wait_load(T_100US);
  localparam logic [19:0] W_40    = wait_load(T_40US);
  localparam logic [19:0] W_LONG  = wait_load(T_LONG);
  localparam logic [19:0] W_NIB   = wait_load(T_NIB);

  state_t      state;
  op_t         op;
  logic [7:0]  byte_q;
  logic [3:0]  step;
  logic [19:0] cnt;
  logic        done;
  logic        inited;
  logic [4:0]  ack;
  logic        xfer_start;
  logic [3:0]  xfer_nib;
  logic        xfer_rs;
  logic        xfer_done;
  logic [7:0]  init_b;

  assign init_b = init_byte(step);
  assign rwlcd  = 1'b0;

  assign bus.lcdreset = ack[0];
  assign bus.lcdclear = ack[1];
  assign bus.lcdhome  = ack[2];
  assign bus.lcdaddr  = ack[3];
  assign bus.lcddata  = ack[4];

  // Wait after the last nibble of a write; init steps 0..3 are single nibbles.
  function automatic logic [19:0] post_load(input op_t o, input logic [3:0] s);
    if (o == OP_RESET) begin
      case (s)
        4'd0:    return W_4100;
        4'd1:    return W_100;
        4'd7:    return W_LONG;
        default: return W_40;
      endcase
    end
    if (o == OP_CLEAR || o == OP_HOME) return W_LONG;
    return W_40;
  endfunction

  always_ff @(posedge CCLK or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op         <= OP_RESET;
      byte_q     <= 8'h00;
      step       <= 4'd0;
      cnt        <= 20'd0;
      done       <= 1'b0;
      inited     <= 1'b0;
      ack        <= 5'd0;
      xfer_start <= 1'b0;
      xfer_nib   <= 4'h0;
      xfer_rs    <= 1'b0;
    end else begin
      xfer_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!done) begin
            if (bus.resetlcd) begin
              op    <= OP_RESET;
              state <= ST_LOAD;
            end else if (inited) begin
              if (bus.clearlcd) begin
                op     <= OP_CLEAR;
                byte_q <= CMD_CLEAR;
                state  <= ST_LOAD;
              end else if (bus.homelcd) begin
                op     <= OP_HOME;
                byte_q <= CMD_HOME;
                state  <= ST_LOAD;
              end else if (bus.addrlcd) begin
                op     <= OP_ADDR;
                byte_q <= CMD_DDRAM | {1'b0, bus.lcddatin[6:0]};
                state  <= ST_LOAD;
              end else if (bus.datalcd) begin
                op     <= OP_DATA;
                byte_q <= bus.lcddatin;
                state  <= ST_LOAD;
              end
            end
          end
        end
        ST_LOAD: begin
          if (op == OP_RESET) begin
            cnt   <= W_PWRUP;
            step  <= 4'd0;
            state <= ST_PWR;
          end else begin
            xfer_start <= 1'b1;
            xfer_nib   <= byte_q[7:4];
            xfer_rs    <= (op == OP_DATA);
            state      <= ST_NIB_HI;
          end
        end
        ST_PWR: begin
          if (cnt != 20'd0) cnt <= cnt - 20'd1;
          else state <= ST_INIT_STEP;
        end
        ST_INIT_STEP: begin
          if (step < 4'd4) begin
            xfer_start <= 1'b1;
            xfer_nib   <= init_nibble(step);
            xfer_rs    <= 1'b0;
            state      <= ST_NIB_LO;
          end else if (step < 4'd8) begin
            byte_q     <= init_b;
            xfer_start <= 1'b1;
            xfer_nib   <= init_b[7:4];
            xfer_rs    <= 1'b0;
            state      <= ST_NIB_HI;
          end else begin
            inited <= 1'b1;
            done   <= 1'b1;
            ack    <= ack_for(op);
            state  <= ST_DONE;
          end
        end
        ST_NIB_HI: begin
          if (xfer_done) begin
            cnt   <= W_NIB;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt != 20'd0) begin
            cnt <= cnt - 20'd1;
          end else begin
            xfer_start <= 1'b1;
            xfer_nib   <= byte_q[3:0];
            state      <= ST_NIB_LO;
          end
        end
        ST_NIB_LO: begin
          if (xfer_done) begin
            cnt   <= post_load(op, step);
            state <= ST_POST;
          end
        end
        ST_POST: begin
          if (cnt != 20'd0) begin
            cnt <= cnt - 20'd1;
          end else if (op == OP_RESET) begin
            step  <= step + 4'd1;
            state <= ST_INIT_STEP;
          end else begin
            done  <= 1'b1;
            ack   <= ack_for(op);
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.initlcd) begin
            done  <= 1'b0;
            ack   <= 5'd0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  lcd_nibble_xfer #(
    .T_SETUP (T_SETUP),
    .T_E     (T_E),
    .T_HOLD  (T_HOLD)
  ) u_xfer (
    .clk       (CCLK),
    .rst       (reset),
    .start     (xfer_start),
    .nibble    (xfer_nib),
    .rs        (xfer_rs),
    .lcdd      (lcdd),
    .rslcd     (rslcd),
    .elcd      (elcd),
    .xfer_done (xfer_done)
  );
endmodule

// File: tb/tb_lcd_nibble_driver.sv
// tb/tb_lcd_nibble_driver.sv - scoreboard bench for lcd_nibble_driver with scaled timing
module tb_lcd_nibble_driver;
  logic       CCLK = 1'b0;
  logic       reset = 1'b1;
  logic       rslcd, rwlcd, elcd;
  logic [3:0] lcdd;

  lcd_nibble_driver_if bus();

  lcd_nibble_driver #(
    .T_PWRUP(100), .T_4100US(40), .T_100US(10), .T_40US(8), .T_LONG(30),
    .T_SETUP(2), .T_E(12), .T_HOLD(2), .T_NIB(4)
  ) dut (
    .CCLK  (CCLK),
    .reset (reset),
    .bus   (bus.slave),
    .rslcd (rslcd),
    .rwlcd (rwlcd),
    .elcd  (elcd),
    .lcdd  (lcdd)
  );

  always #5 CCLK = ~CCLK;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulse_count = 0;
  int last_rise = 0;
  int width = 0;
  logic e_prev = 1'b0;
  logic [4:0] exp_v;
  logic [4:0] exp_q[$];
  logic [4:0] acks;

  assign acks = {bus.lcddata, bus.lcdaddr, bus.lcdhome, bus.lcdclear, bus.lcdreset};

  always @(posedge CCLK) cyc++;

  // Each elcd pulse pops one {rs, nibble} and must be exactly 12 cycles wide.
  always @(negedge CCLK) begin
    if (reset) begin
      e_prev = 1'b0;
      width = 0;
    end else begin
      if (elcd && !e_prev) begin
        pulse_count++;
        last_rise = cyc;
        width = 1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: got rs=%b lcdd=%h, no nibble expected", rslcd, lcdd);
        end else begin
          exp_v = exp_q.pop_front();
          if ({rwlcd, rslcd, lcdd} !== {1'b0, exp_v}) begin
            n_fail++;
            $display("FAIL nibble: got rw=%b rs=%b lcdd=%h, expected rw=0 rs=%b lcdd=%h",
                     rwlcd, rslcd, lcdd, exp_v[4], exp_v[3:0]);
          end
        end
      end else if (elcd) begin
        width++;
      end else if (e_prev) begin
        n_checks++;
        if (width != 12) begin
          n_fail++;
          $display("FAIL e_width: got %0d cycles, expected 12", width);
        end
      end
      e_prev = elcd;
    end
  end

  task automatic push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endtask

  task automatic push_init();
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CCLK);
      if (acks != 5'd0) ok = 1'b1;
    end
  endtask

  task automatic wait_pulses(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CCLK);
      if (pulse_count >= target) ok = 1'b1;
    end
  endtask

  task automatic pulse_init();
    @(posedge CCLK); #1 bus.initlcd = 1'b1;
    @(posedge CCLK); #1 bus.initlcd = 1'b0;
  endtask

  task automatic test_reset();
    bus.resetlcd = 1'b0; bus.clearlcd = 1'b0; bus.homelcd = 1'b0;
    bus.addrlcd = 1'b0; bus.datalcd = 1'b0; bus.lcddatin = 8'h00; bus.initlcd = 1'b0;
    repeat (3) @(negedge CCLK);
    n_checks++;
    if ({elcd, rslcd, rwlcd, lcdd, acks} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_state: got e=%b rs=%b rw=%b lcdd=%h acks=%b, expected all 0",
               elcd, rslcd, rwlcd, lcdd, acks);
    end
    @(posedge CCLK); #1 reset = 1'b0;
  endtask

  task automatic test_not_inited();
    int pc0;
    pc0 = pulse_count;
    @(posedge CCLK); #1 bus.datalcd = 1'b1; bus.lcddatin = 8'h55;
    repeat (200) @(negedge CCLK);
    n_checks++;
    if (pulse_count != pc0) begin
      n_fail++;
      $display("FAIL pre_init_pulses: got %0d pulses, expected 0", pulse_count - pc0);
    end
    n_checks++;
    if (acks !== 5'd0) begin
      n_fail++;
      $display("FAIL pre_init_ack: got %b, expected 00000", acks);
    end
  endtask

  task automatic test_init_sequence();
    int pc0, req;
    bit ok;
    pc0 = pulse_count;
    @(posedge CCLK); #1 bus.resetlcd = 1'b1;
    req = cyc;
    push_init();
    wait_pulses(pc0 + 1, 400, ok);
    n_checks++;
    if (!ok || (last_rise - req) < 100) begin
      n_fail++;
      $display("FAIL pwrup_wait: first rise after %0d cycles (seen=%b), expected >= 100", last_rise - req, ok);
    end
    wait_ack(3000, ok);
    n_checks++;
    if (!ok || acks !== 5'b00001) begin
      n_fail++;
      $display("FAIL init_ack: got %b, expected 00001", acks);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL init_nibbles: %0d nibbles missing, expected 0", exp_q.size());
    end
    bus.resetlcd = 1'b0;
    push_byte(1'b1, 8'h55);
    pulse_init();
    wait_ack(500, ok);
    n_checks++;
    if (!ok || acks !== 5'b10000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_data: got acks=%b left=%0d, expected 10000 left=0", acks, exp_q.size());
    end
    bus.datalcd = 1'b0;
    pulse_init();
  endtask

  task automatic test_addr();
    bit ok;
    @(posedge CCLK); #1 bus.addrlcd = 1'b1; bus.lcddatin = 8'h45;
    push_byte(1'b0, 8'hC5);
    wait_ack(500, ok);
    n_checks++;
    if (!ok || acks !== 5'b01000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL addr_ack: got acks=%b left=%0d, expected 01000 left=0", acks, exp_q.size());
    end
    #1 bus.addrlcd = 1'b0;
    repeat (5) @(negedge CCLK);
    n_checks++;
    if (acks !== 5'b01000) begin
      n_fail++;
      $display("FAIL addr_ack_hold: got %b after request drop, expected 01000", acks);
    end
    @(posedge CCLK); #1 bus.initlcd = 1'b1;
    @(negedge CCLK);
    n_checks++;
    if (acks !== 5'b01000) begin
      n_fail++;
      $display("FAIL addr_ack_before_init: got %b, expected 01000", acks);
    end
    @(posedge CCLK); #1 bus.initlcd = 1'b0;
    @(negedge CCLK);
    n_checks++;
    if (acks !== 5'b00000) begin
      n_fail++;
      $display("FAIL addr_ack_clear: got %b, expected 00000", acks);
    end
  endtask

  task automatic test_data_resample();
    bit ok;
    @(posedge CCLK); #1 bus.datalcd = 1'b1; bus.lcddatin = 8'h41;
    push_byte(1'b1, 8'h41);
    repeat (10) @(posedge CCLK);
    #1 bus.lcddatin = 8'hFF;
    wait_ack(500, ok);
    n_checks++;
    if (!ok || acks !== 5'b10000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL data_ack: got acks=%b left=%0d, expected 10000 left=0", acks, exp_q.size());
    end
    bus.datalcd = 1'b0;
    pulse_init();
  endtask

  task automatic test_priority();
    bit ok;
    @(posedge CCLK); #1 bus.clearlcd = 1'b1; bus.datalcd = 1'b1; bus.lcddatin = 8'h33;
    push_byte(1'b0, 8'h01);
    wait_ack(500, ok);
    n_checks++;
    if (!ok || acks !== 5'b00010 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL prio_clear: got acks=%b left=%0d, expected 00010 left=0", acks, exp_q.size());
    end
    bus.clearlcd = 1'b0;
    push_byte(1'b1, 8'h33);
    pulse_init();
    wait_ack(500, ok);
    n_checks++;
    if (!ok || acks !== 5'b10000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL prio_data: got acks=%b left=%0d, expected 10000 left=0", acks, exp_q.size());
    end
    bus.datalcd = 1'b0;
    pulse_init();
  endtask

  task automatic test_async_reset();
    int pc0, req;
    bit ok;
    pc0 = pulse_count;
    @(posedge CCLK); #1 bus.resetlcd = 1'b1;
    push_init();
    wait_pulses(pc0 + 3, 600, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL third_nibble: got %0d pulses, expected 3", pulse_count - pc0);
    end
    repeat (3) @(negedge CCLK);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({elcd, rslcd, lcdd, acks} !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset: got e=%b rs=%b lcdd=%h acks=%b, expected all 0", elcd, rslcd, lcdd, acks);
    end
    bus.resetlcd = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CCLK);
    #1 reset = 1'b0;
    pc0 = pulse_count;
    @(posedge CCLK); #1 bus.resetlcd = 1'b1;
    req = cyc;
    push_init();
    wait_pulses(pc0 + 1, 400, ok);
    n_checks++;
    if (!ok || (last_rise - req) < 100) begin
      n_fail++;
      $display("FAIL restart_pwrup: first rise after %0d cycles (seen=%b), expected >= 100", last_rise - req, ok);
    end
    wait_ack(3000, ok);
    n_checks++;
    if (!ok || acks !== 5'b00001 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart_ack: got acks=%b left=%0d, expected 00001 left=0", acks, exp_q.size());
    end
    bus.resetlcd = 1'b0;
    pulse_init();
  endtask

  initial begin
    test_reset();
    test_not_inited();
    test_init_sequence();
    test_addr();
    test_data_resample();
    test_priority();
    test_async_reset();
    repeat (20) @(negedge CCLK);
    n_checks++;
    if (exp_q.size() != 0 || acks !== 5'd0) begin
      n_fail++;
      $display("FAIL final_idle: got left=%0d acks=%b, expected left=0 acks=00000", exp_q.size(), acks);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
